// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and a parity helper.
// Used by the transmitter and intended for reuse by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Payload is zero-extended to 9 bits, which leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: counts 0..CLKS_PER_BIT-1 and flags the last count.
// Holding clear keeps the counter at zero so a new frame starts on a full bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching real flops.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input handshake.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits; tx is registered.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2) begin : g_bad_params
        $error("uart_tx_param: illegal parameter combination");
    end

    localparam int               IDX_W     = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;

    logic                 w_bit_tick;
    logic                 w_baud_clear;
    logic                 w_handshake;

    assign w_baud_clear = (r_state == S_IDLE);
    assign w_handshake  = valid && r_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_baud_clear),
        .bit_tick(w_bit_tick)
    );

    // tx is always loaded with the value of the bit period that starts at this edge,
    // so the line changes exactly on baud boundaries with no combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_shift    <= data_in;
                        r_bit_idx  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_parity   <= parity_bit(9'(data_in), PARITY_MODE);
                    end
                end
                S_START: begin
                    if (w_bit_tick) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                S_DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == LAST_IDX) begin
                            if (PARITY_MODE != PARITY_NONE) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_tick) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: four transmitter configurations (8N1, 8E1, 8O1, 7N2) at 4 clocks per bit.
// Expected serial frames are hand-written bit patterns, sent bit 0 first.
module tb_uart_tx_param;

    localparam int CPB = 4;

    typedef struct {
        int          sel;
        logic [7:0]  din;
        logic [15:0] bits;
        int          nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid = '0;
    logic [7:0] d0 = '0;
    logic [7:0] d1 = '0;
    logic [7:0] d2 = '0;
    logic [6:0] d3 = '0;
    logic [3:0] tx;
    logic [3:0] ready;
    logic [3:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .data_in(d0), .valid(valid[0]),
        .ready(ready[0]), .tx(tx[0]), .busy(busy[0]));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .data_in(d1), .valid(valid[1]),
        .ready(ready[1]), .tx(tx[1]), .busy(busy[1]));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .data_in(d2), .valid(valid[2]),
        .ready(ready[2]), .tx(tx[2]), .busy(busy[2]));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .data_in(d3), .valid(valid[3]),
        .ready(ready[3]), .tx(tx[3]), .busy(busy[3]));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [7:0] data);
        case (sel)
            0:       d0 = data;
            1:       d1 = data;
            2:       d2 = data;
            default: d3 = data[6:0];
        endcase
    endtask

    task automatic wait_ready(input int sel);
        int n = 0;
        @(negedge clk);
        while (!ready[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready_wait%0d", sel), {15'b0, ready[sel]}, 16'd1);
    endtask

    // Single-cycle valid pulse; returns just after the handshake edge.
    task automatic send(input int sel, input logic [7:0] data);
        wait_ready(sel);
        drive(sel, data);
        valid[sel] = 1'b1;
        @(posedge clk);
        #1 valid[sel] = 1'b0;
    endtask

    // Samples every cycle of a frame starting the cycle after the handshake,
    // then the single idle cycle that follows it.
    task automatic check_frame(input int sel, input logic [15:0] bits, input int nbits,
                               input string tag);
        for (int j = 0; j < nbits * CPB; j++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, j),
                  {13'b0, tx[sel], busy[sel], ready[sel]},
                  {13'b0, bits[j / CPB], 2'b10});
        end
        @(negedge clk);
        check($sformatf("%s_end", tag), {13'b0, tx[sel], busy[sel], ready[sel]}, 16'b101);
    endtask

    vec_t vecs[6];

    initial begin
        logic all_high;

        vecs[0] = '{0, 8'hA5, 16'b1_10100101_0,   10};
        vecs[1] = '{1, 8'hA5, 16'b1_0_10100101_0, 11};
        vecs[2] = '{2, 8'hA5, 16'b1_1_10100101_0, 11};
        vecs[3] = '{1, 8'h07, 16'b1_1_00000111_0, 11};
        vecs[4] = '{3, 8'h55, 16'b11_1010101_0,   10};
        vecs[5] = '{0, 8'h3C, 16'b1_00111100_0,   10};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tx",    {12'b0, tx},    16'hF);
        check("rst_ready", {12'b0, ready}, 16'hF);
        check("rst_busy",  {12'b0, busy},  16'h0);

        all_high = 1'b1;
        repeat (100) begin
            @(negedge clk);
            all_high &= &tx;
        end
        check("idle_100", {15'b0, all_high}, 16'd1);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].sel, vecs[i].din);
            check_frame(vecs[i].sel, vecs[i].bits, vecs[i].nbits, $sformatf("vec%0d", i));
        end

        // valid held high: second start bit follows exactly one idle cycle.
        wait_ready(3);
        drive(3, 8'h55);
        valid[3] = 1'b1;
        @(posedge clk);
        #1;
        check_frame(3, 16'b11_1010101_0, 10, "b2b1");
        @(posedge clk);
        #1 valid[3] = 1'b0;
        check_frame(3, 16'b11_1010101_0, 10, "b2b2");

        // valid raised mid-frame and dropped before ready returns: ignored.
        send(0, 8'hA5);
        fork
            check_frame(0, 16'b1_10100101_0, 10, "ign");
            begin
                repeat (12) @(negedge clk);
                drive(0, 8'h3C);
                valid[0] = 1'b1;
                repeat (10) @(negedge clk);
                valid[0] = 1'b0;
            end
        join
        repeat (8) begin
            @(negedge clk);
            check("ign_idle", {14'b0, tx[0], busy[0]}, 16'b10);
        end

        // valid raised mid-frame and still high when ready returns: queued frame is sent.
        send(0, 8'hA5);
        fork
            check_frame(0, 16'b1_10100101_0, 10, "hold");
            begin
                repeat (20) @(negedge clk);
                drive(0, 8'h3C);
                valid[0] = 1'b1;
            end
        join
        @(posedge clk);
        #1 valid[0] = 1'b0;
        check_frame(0, 16'b1_00111100_0, 10, "hold2");

        // Reset during data bit 3 aborts the frame on the next cycle.
        send(0, 8'hA5);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst", {13'b0, tx[0], busy[0], ready[0]}, 16'b101);
        send(0, 8'h81);
        check_frame(0, 16'b1_10000001_0, 10, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART serial transmitter; next-generation replacement for the fixed 8N1 transmitter driven by the debounced transmit button in the tiny-tapeout top level. Supports configurable data width, optional even/odd parity, 1 or 2 stop bits, and a compile-time baud divisor. Uses a valid/ready handshake instead of a level-sensitive transmit strobe, so a FIFO or button logic can drive it. Output tx drives uo_out[4] in the top level.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
data_in  input  DATA_BITS  payload; sampled on handshake
valid  input  1  upstream has a frame to send
ready  output  1  block can accept a frame this cycle
tx  output  1  serial line; idles high
busy  output  1  high from handshake cycle+1 until the frame completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst high at a clock edge): state=IDLE, tx=1, ready=1, busy=0, counters cleared. Reset takes priority over every other event. Reset mid-frame aborts the frame immediately: tx=1 on the next cycle, and no partial stop bits are sent.
- Handshake: transfer occurs at the edge where valid && ready. data_in is latched into the shift register at that edge. ready=1 only in IDLE. valid while not ready is ignored; no queuing. data_in is don't-care when no transfer occurs.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1. On handshake go to START, reset the baud counter, and compute parity.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles. Shift right on each bit boundary.
  - PARITY: entered only if PARITY_MODE != 0. tx = ^data for even, ~^data for odd, held CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. Then go to IDLE.
- Latency: handshake at edge k -> tx=0 from cycle k+1.
- Frame length: F = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles. busy is high for exactly F cycles.
- Back-to-back frames: ready returns high in the cycle after the last stop-bit cycle (IDLE). The minimum gap between frames is 1 clock of idle-high line beyond the stop bits.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps to 0; bit_tick is asserted at count CLKS_PER_BIT-1. Bit index counter: width $clog2(DATA_BITS+1), wraps at DATA_BITS-1 to exit DATA.
- tx is a registered output; no combinational path from data_in or valid to tx.
- Illegal parameters (DATA_BITS outside 5..9, PARITY_MODE=3, STOP_BITS outside 1..2, CLKS_PER_BIT<2) are rejected by an elaboration-time check.

Decomposition:
- Shared package uart_pkg: state encoding constants (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP) and PARITY_NONE/EVEN/ODD constants. Reused by the future receiver.
- One sub-module: uart_baud_gen (parameter CLKS_PER_BIT; inputs clk, rst, clear; output bit_tick). The FSM, shift register and parity logic stay in uart_tx_param.

Test Plan:
- Reset: hold rst 3 cycles, then release -> tx=1, ready=1, busy=0. valid=0 for 100 cycles -> tx stays 1.
- 8N1, CLKS_PER_BIT=4, data_in=0xA5 with a single valid pulse -> tx sequence per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | 1. busy high for exactly 40 cycles. Start bit begins 1 cycle after handshake.
- 8E1 and 8O1 with 0xA5 (four ones) -> parity bit 0 for even, 1 for odd. 8E1 with 0x07 -> parity bit 1. Frame length 44 cycles.
- 7N2 with data_in=0x55 -> 7 data bits 1,0,1,0,1,0,1, then 8 cycles high. valid held high continuously -> next start bit exactly 1 idle cycle after the stop bits. ready pulses high for 1 cycle per frame.
- Handshake ignore: assert valid with data 0x3C mid-frame while ready=0 -> no effect on the current frame, and 0x3C is not sent unless valid is still high when ready returns.
- Reset mid-frame: assert rst during DATA bit 3 -> next cycle tx=1, ready=1, busy=0. A new 0x81 frame then transmits cleanly.
